// File: rtl/data_memory_responder_if.sv
// Load/store bus between the CPU MEM stage (master) and the data-memory responder (slave).
interface data_memory_responder_if #(
   parameter int unsigned DATA_W = 64
);
   logic              MemRead;
   logic              MemWrite;
   logic [63:0]       Address;
   logic [DATA_W-1:0] WriteData;
   logic [DATA_W-1:0] ReadData;
   logic              mem_ready;
   logic              addr_error;
   logic              stall;

   modport master (
      output MemRead, MemWrite, Address, WriteData,
      input  ReadData, mem_ready, addr_error, stall
   );

   modport slave (
      input  MemRead, MemWrite, Address, WriteData,
      output ReadData, mem_ready, addr_error, stall
   );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory: samples a load/store in IDLE, waits out the latency in BUSY, then
// pulses mem_ready for one RESP cycle. Stores commit and loads capture on the edge entering RESP.
module data_memory_responder #(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input logic                   clk,
   input logic                   reset,
   data_memory_responder_if.slave bus
);
   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} stateT;

   stateT             stateQ, stateD;
   logic [3:0]        countQ, countD;
   logic              opWriteQ;
   logic [63:0]       addrQ;
   logic [DATA_W-1:0] wdataQ;
   logic [DATA_W-1:0] readDataQ;
   logic              errQ;
   logic [DATA_W-1:0] storage [DEPTH_WORDS];

   logic              req;
   logic              stall;
   logic              commit;
   logic              accWrite;
   logic [63:0]       accAddr;
   logic [DATA_W-1:0] accData;
   logic [IDX_W-1:0]  accIdx;
   logic              accErr;

   assign req = bus.MemRead | bus.MemWrite;

   // Next-state, latency countdown and stall; commit marks the edge that enters RESP.
   always_comb begin
      stateD = stateQ;
      countD = countQ;
      commit = 1'b0;
      stall  = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (req) begin
               stall = 1'b1;
               if (LATENCY == 1) begin
                  stateD = StResp;
                  commit = 1'b1;
               end else begin
                  stateD = StBusy;
                  countD = LAT_M1;
               end
            end
         end
         StBusy: begin
            stall = 1'b1;
            if (countQ == 4'd1) begin
               stateD = StResp;
               commit = 1'b1;
            end else begin
               countD = countQ - 4'd1;
            end
         end
         StResp:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   // Operands of the completing access: live inputs when completing straight out of IDLE
   // (single-cycle latency), otherwise the copies sampled at request time.
   always_comb begin
      if (stateQ == StIdle) begin
         accWrite = bus.MemWrite;
         accAddr  = bus.Address;
         accData  = bus.WriteData;
      end else begin
         accWrite = opWriteQ;
         accAddr  = addrQ;
         accData  = wdataQ;
      end
   end

   assign accIdx = accAddr[IDX_W+2:3];
   assign accErr = (accAddr[2:0] != 3'd0) || (accAddr[63:IDX_W+3] != '0);

   // Control state, sampled request and registered response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ    <= StIdle;
         countQ    <= 4'd0;
         opWriteQ  <= 1'b0;
         addrQ     <= 64'd0;
         wdataQ    <= '0;
         readDataQ <= '0;
         errQ      <= 1'b0;
      end else begin
         stateQ <= stateD;
         countQ <= countD;
         if (stateQ == StIdle && req) begin
            opWriteQ <= bus.MemWrite;  // write wins when both strobes are high
            addrQ    <= bus.Address;
            wdataQ   <= bus.WriteData;
         end
         if (commit) begin
            errQ <= accErr;
            if (!accErr && !accWrite) begin
               readDataQ <= storage[accIdx];
            end
         end
      end
   end

   // Storage array is never cleared; reset gates the write so an aborted access commits nothing.
   always_ff @(posedge clk) begin
      if (reset && commit && accWrite && !accErr) begin
         storage[accIdx] <= accData;
      end
   end

   assign bus.ReadData   = readDataQ;
   assign bus.mem_ready  = (stateQ == StResp);
   assign bus.addr_error = (stateQ == StResp) && errQ;
   assign bus.stall      = stall;
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: one instance with LATENCY=2, one with LATENCY=1, checked
// against an array-based reference memory.
module tb_data_memory_responder;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   data_memory_responder_if #(.DATA_W(64)) busA ();
   data_memory_responder_if #(.DATA_W(64)) busB ();

   data_memory_responder #(.DATA_W(64), .DEPTH_WORDS(256), .LATENCY(2)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   data_memory_responder #(.DATA_W(64), .DEPTH_WORDS(256), .LATENCY(1)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   logic [63:0] refMem [2][256];
   logic [63:0] expRd [2];
   int unsigned lat [2] = '{2, 1};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic driveReq(input int sel, input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] data);
      if (sel == 0) begin
         busA.MemRead = rd; busA.MemWrite = wr; busA.Address = addr; busA.WriteData = data;
      end else begin
         busB.MemRead = rd; busB.MemWrite = wr; busB.Address = addr; busB.WriteData = data;
      end
   endtask

   task automatic sampleOut(input int sel, output logic rdy, output logic err,
                            output logic stl, output logic [63:0] rdata);
      if (sel == 0) begin
         rdy = busA.mem_ready; err = busA.addr_error; stl = busA.stall; rdata = busA.ReadData;
      end else begin
         rdy = busB.mem_ready; err = busB.addr_error; stl = busB.stall; rdata = busB.ReadData;
      end
   endtask

   // One complete access; called just after a rising edge with the DUT idle.
   task automatic access(input int sel, input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] data, input string tag);
      logic        isErr, rdy, err, stl;
      logic [63:0] rdv;
      isErr = (addr % 8 != 0) || (addr >= 64'd2048);
      driveReq(sel, rd, wr, addr, data);
      #1;
      sampleOut(sel, rdy, err, stl, rdv);
      check({tag, ".stallReq"}, {63'd0, stl}, 64'd1);
      @(posedge clk);
      #1;
      driveReq(sel, 1'b0, 1'b0, 64'd0, 64'd0);
      if (!isErr) begin
         if (wr) refMem[sel][addr / 8] = data;
         else    expRd[sel] = refMem[sel][addr / 8];
      end
      // mem_ready must appear in the LATENCY-th cycle after the sample edge, never earlier
      for (int c = 1; c <= int'(lat[sel]); c++) begin
         @(negedge clk);
         sampleOut(sel, rdy, err, stl, rdv);
         check({tag, ".ready"}, {63'd0, rdy}, {63'd0, c == int'(lat[sel])});
         check({tag, ".stall"}, {63'd0, stl}, {63'd0, c < int'(lat[sel])});
         if (c == int'(lat[sel])) begin
            check({tag, ".err"}, {63'd0, err}, {63'd0, isErr});
            check({tag, ".rdata"}, rdv, expRd[sel]);
         end else begin
            check({tag, ".errIdle"}, {63'd0, err}, 64'd0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic [63:0] a, d;
      int          kind, op;

      reset = 1'b1;
      driveReq(0, 1'b0, 1'b0, 64'd0, 64'd0);
      driveReq(1, 1'b0, 1'b0, 64'd0, 64'd0);
      #1 reset = 1'b0;
      #2;
      check("rst.A.rdata", busA.ReadData, 64'd0);
      check("rst.A.ready", {63'd0, busA.mem_ready}, 64'd0);
      check("rst.A.err", {63'd0, busA.addr_error}, 64'd0);
      check("rst.A.stall", {63'd0, busA.stall}, 64'd0);
      check("rst.B.rdata", busB.ReadData, 64'd0);
      check("rst.B.ready", {63'd0, busB.mem_ready}, 64'd0);
      expRd[0] = 64'd0;
      expRd[1] = 64'd0;
      @(posedge clk);
      #1 reset = 1'b1;

      // Give every word a known value in both instances.
      for (int i = 0; i < 256; i++) begin
         access(0, 1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, "fillA");
         access(1, 1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, "fillB");
      end

      // Store then load back.
      access(0, 1'b0, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, "t1.st");
      access(0, 1'b1, 1'b0, 64'h10, 64'd0, "t1.ld");
      // Misaligned store is rejected and leaves the word intact.
      access(0, 1'b0, 1'b1, 64'h13, 64'hDEAD_BEEF, "t2.st");
      access(0, 1'b1, 1'b0, 64'h10, 64'd0, "t2.ld");
      // Out-of-range load keeps the previous ReadData.
      access(0, 1'b1, 1'b0, 64'h800, 64'd0, "t3.ld");
      // Both strobes high behaves as a store.
      access(0, 1'b1, 1'b1, 64'h8, 64'hAA, "t4.both");
      access(0, 1'b1, 1'b0, 64'h8, 64'd0, "t4.ld");

      // Reset during BUSY aborts the store.
      driveReq(0, 1'b0, 1'b1, 64'h20, 64'h55);
      @(posedge clk);
      #1 driveReq(0, 1'b0, 1'b0, 64'd0, 64'd0);
      #2 reset = 1'b0;
      #1;
      check("t5.rdata", busA.ReadData, 64'd0);
      check("t5.ready", {63'd0, busA.mem_ready}, 64'd0);
      check("t5.err", {63'd0, busA.addr_error}, 64'd0);
      check("t5.stall", {63'd0, busA.stall}, 64'd0);
      check("t5.B.rdata", busB.ReadData, 64'd0);
      expRd[0] = 64'd0;
      expRd[1] = 64'd0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("t5.stallRel", {63'd0, busA.stall}, 64'd0);
      access(0, 1'b1, 1'b0, 64'h20, 64'd0, "t5.ld");

      // Single-cycle latency, requests held back-to-back: stall 1,0,1,0.
      driveReq(1, 1'b1, 1'b0, 64'h0, 64'd0);
      #1;
      check("t6.stall0", {63'd0, busB.stall}, 64'd1);
      check("t6.ready0", {63'd0, busB.mem_ready}, 64'd0);
      @(posedge clk);
      #1 driveReq(1, 1'b1, 1'b0, 64'h8, 64'd0);
      expRd[1] = refMem[1][0];
      @(negedge clk);
      check("t6.stall1", {63'd0, busB.stall}, 64'd0);
      check("t6.ready1", {63'd0, busB.mem_ready}, 64'd1);
      check("t6.rdata1", busB.ReadData, expRd[1]);
      @(posedge clk);
      #1;
      check("t6.stall2", {63'd0, busB.stall}, 64'd1);
      check("t6.ready2", {63'd0, busB.mem_ready}, 64'd0);
      @(posedge clk);
      #1 driveReq(1, 1'b0, 1'b0, 64'd0, 64'd0);
      expRd[1] = refMem[1][1];
      @(negedge clk);
      check("t6.stall3", {63'd0, busB.stall}, 64'd0);
      check("t6.ready3", {63'd0, busB.mem_ready}, 64'd1);
      check("t6.rdata3", busB.ReadData, expRd[1]);
      @(posedge clk);
      #1;

      // Randomized mix of loads, stores, misaligned and out-of-range accesses.
      for (int n = 0; n < 120; n++) begin
         kind = $urandom_range(0, 9);
         op   = $urandom_range(0, 3);
         d    = {$urandom, $urandom};
         if (kind == 0)      a = 64'($urandom_range(0, 255) * 8 + $urandom_range(1, 7));
         else if (kind == 1) a = {$urandom, $urandom} | 64'h800;
         else                a = 64'($urandom_range(0, 255) * 8);
         access(n % 2, (op != 2), (op >= 2), a, d, (n % 2 == 0) ? "rndA" : "rndB");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
